// File: rtl/mac_feeder.sv
// mac_feeder: buffers signed x/w pairs and streams them into the MAC datapath.
// A run is CLEAR (accumulator clear), one RUN cycle per pair, then DONE.
module mac_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_x,
    input  logic [WIDTH-1:0] ld_w,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] w,
    output logic             enable,
    output logic             acc_clr,
    output logic             done
);

    // Address width into the storage arrays; pointers carry one extra bit for DEPTH.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

    state_e           state;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem_x [DEPTH];
    logic [WIDTH-1:0] mem_w [DEPTH];
    logic             wr_fire;

    // Load acceptance is purely a function of state and fill level.
    always_comb begin
        ld_ready = (state == StIdle) && (count < CNT_W'(DEPTH));
        wr_fire  = ld_valid && ld_ready;
    end

    // Pair storage; contents are don't-care after reset, so no reset is applied.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_x[wr_ptr[AW-1:0]] <= ld_x;
            mem_w[wr_ptr[AW-1:0]] <= ld_w;
        end
    end

    // Sequencer FSM with all MAC-facing outputs registered.
    // count is frozen outside IDLE, so it doubles as the run length sampled in CLEAR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc_clr <= 1'b0;
            enable  <= 1'b0;
            x       <= '0;
            w       <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (wr_fire) begin
                        count  <= count + CNT_W'(1);
                        wr_ptr <= wr_ptr + CNT_W'(1);
                    end
                    // A write accepted alongside start joins this run.
                    if (start && ((count != '0) || wr_fire)) begin
                        state   <= StClear;
                        busy    <= 1'b1;
                        acc_clr <= 1'b1;
                    end
                end
                StClear: begin
                    acc_clr <= 1'b0;
                    enable  <= 1'b1;
                    x       <= mem_x[0];
                    w       <= mem_w[0];
                    rd_ptr  <= CNT_W'(1);
                    state   <= StRun;
                end
                StRun: begin
                    // rd_ptr is the index of the next pair; reaching count means the last
                    // pair is on the outputs now.
                    if (rd_ptr == count) begin
                        enable <= 1'b0;
                        x      <= '0;
                        w      <= '0;
                        done   <= 1'b1;
                        state  <= StDone;
                    end else begin
                        x      <= mem_x[rd_ptr[AW-1:0]];
                        w      <= mem_w[rd_ptr[AW-1:0]];
                        rd_ptr <= rd_ptr + CNT_W'(1);
                    end
                end
                StDone: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    count  <= '0;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// Testbench for mac_feeder: per-cycle comparison against a run-schedule model,
// plus a behavioural MAC fed by the DUT to check the dot product at done.
module tb_mac_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_x = '0;
    logic [WIDTH-1:0] ld_w = '0;
    logic             start = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] w;
    logic             enable;
    logic             acc_clr;
    logic             done;

    mac_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_x     (ld_x),
        .ld_w     (ld_w),
        .start    (start),
        .busy     (busy),
        .count    (count),
        .x        (x),
        .w        (w),
        .enable   (enable),
        .acc_clr  (acc_clr),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Downstream MAC: cleared by acc_clr, accumulates x*w when enabled.
    logic signed [15:0] prod;
    logic signed [31:0] mac;
    assign prod = $signed(x) * $signed(w);
    always_ff @(posedge clk) begin
        if (acc_clr) mac <= '0;
        else if (enable) mac <= mac + 32'(prod);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: pending buffer, and for an active run the vector plus the
    // cycle offset since the start edge (1 = clear, 2..n+1 = pairs, n+2 = done).
    typedef struct {
        int x;
        int w;
    } pair_t;

    pair_t pend_q[$];
    pair_t run_q[$];
    int    mdl_t = -1;
    int    mdl_n = 0;
    int    last_done_mac = 0;

    task automatic cycle();
        int    ex_busy, ex_en, ex_done, ex_clr, ex_x, ex_w, ex_cnt, ex_rdy, dot;
        bit    do_push, do_start;
        pair_t p;
        @(negedge clk);
        ex_x = 0;
        ex_w = 0;
        ex_en = 0;
        ex_done = 0;
        ex_clr = 0;
        if (mdl_t < 0) begin
            ex_busy = 0;
            ex_cnt  = pend_q.size();
            ex_rdy  = int'(pend_q.size() < DEPTH);
        end else begin
            ex_busy = 1;
            ex_cnt  = mdl_n;
            ex_rdy  = 0;
            ex_clr  = int'(mdl_t == 1);
            ex_done = int'(mdl_t == mdl_n + 2);
            if (mdl_t >= 2 && mdl_t <= mdl_n + 1) begin
                ex_en = 1;
                ex_x  = run_q[mdl_t-2].x;
                ex_w  = run_q[mdl_t-2].w;
            end
        end
        check("busy", int'(busy), ex_busy);
        check("enable", int'(enable), ex_en);
        check("done", int'(done), ex_done);
        check("acc_clr", int'(acc_clr), ex_clr);
        check("x", int'($signed(x)), ex_x);
        check("w", int'($signed(w)), ex_w);
        check("count", int'(count), ex_cnt);
        check("ld_ready", int'(ld_ready), ex_rdy);
        if (ex_done == 1) begin
            dot = 0;
            foreach (run_q[i]) dot += run_q[i].x * run_q[i].w;
            check("mac_dot", int'(mac), dot);
            last_done_mac = int'(mac);
        end
        do_push  = (mdl_t < 0) && ld_valid && (pend_q.size() < DEPTH);
        do_start = (mdl_t < 0) && start && ((pend_q.size() > 0) || do_push);
        p.x = int'($signed(ld_x));
        p.w = int'($signed(ld_w));
        @(posedge clk);
        if (rst) begin
            if (mdl_t < 0) begin
                if (do_push) pend_q.push_back(p);
                if (do_start) begin
                    run_q = pend_q;
                    mdl_n = pend_q.size();
                    mdl_t = 1;
                end
            end else if (mdl_t == mdl_n + 2) begin
                mdl_t = -1;
                pend_q.delete();
                run_q.delete();
            end else begin
                mdl_t++;
            end
        end
        #1;
    endtask

    task automatic load(input int px, input int pw);
        ld_valid = 1'b1;
        ld_x = WIDTH'(px);
        ld_w = WIDTH'(pw);
        cycle();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_to_idle();
        for (int k = 0; k < 3 * DEPTH && mdl_t >= 0; k++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_enable"}, int'(enable), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_acc_clr"}, int'(acc_clr), 0);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_w"}, int'(w), 0);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_ld_ready"}, int'(ld_ready), 1);
    endtask

    typedef struct {
        int n;
        int xs[4];
        int ws[4];
        int exp_dot;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // Directed vectors with hand-computed dot products; run back-to-back.
        tbl[0].n = 3; tbl[0].xs = '{2, -4, 7, 0};       tbl[0].ws = '{3, 5, -1, 0};
        tbl[0].exp_dot = -21;
        tbl[1].n = 1; tbl[1].xs = '{5, 0, 0, 0};        tbl[1].ws = '{5, 0, 0, 0};
        tbl[1].exp_dot = 25;
        tbl[2].n = 1; tbl[2].xs = '{-128, 0, 0, 0};     tbl[2].ws = '{127, 0, 0, 0};
        tbl[2].exp_dot = -16256;
        tbl[3].n = 2; tbl[3].xs = '{127, 127, 0, 0};    tbl[3].ws = '{127, 127, 0, 0};
        tbl[3].exp_dot = 32258;
        tbl[4].n = 4; tbl[4].xs = '{1, 2, 3, 4};        tbl[4].ws = '{-1, -2, -3, -4};
        tbl[4].exp_dot = -30;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst = 1'b1;
        cycle();

        // start with an empty buffer is ignored
        pulse_start();
        check("empty_start_busy", int'(busy), 0);
        cycle();

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < tbl[i].n; j++) load(tbl[i].xs[j], tbl[i].ws[j]);
            pulse_start();
            run_to_idle();
            check("tbl_dot", last_done_mac, tbl[i].exp_dot);
            check("tbl_count_after", int'(count), 0);
        end

        // Full: 17 pairs offered back to back, only 16 stored
        ld_valid = 1'b1;
        for (int j = 0; j < DEPTH + 1; j++) begin
            ld_x = WIDTH'($urandom);
            ld_w = WIDTH'($urandom);
            cycle();
        end
        ld_valid = 1'b0;
        check("full_count", int'(count), DEPTH);
        check("full_ready", int'(ld_ready), 0);
        pulse_start();
        run_to_idle();

        // start and ld_valid during RUN are ignored
        for (int j = 0; j < 3; j++) load(int'($urandom_range(0, 255)) - 128, 3 - j);
        pulse_start();
        cycle();
        cycle();
        start = 1'b1;
        ld_valid = 1'b1;
        ld_x = 8'h11;
        ld_w = 8'h22;
        cycle();
        start = 1'b0;
        ld_valid = 1'b0;
        run_to_idle();
        cycle();
        check("no_restart_busy", int'(busy), 0);
        check("no_write_count", int'(count), 0);

        // start together with a write: run length 3, last pair (-128,-128)
        load(9, -3);
        load(-6, 4);
        start = 1'b1;
        ld_valid = 1'b1;
        ld_x = 8'h80;
        ld_w = 8'h80;
        cycle();
        start = 1'b0;
        ld_valid = 1'b0;
        run_to_idle();
        check("simul_dot", last_done_mac, -27 - 24 + 16384);

        // Randomized runs with load gaps
        for (int it = 0; it < 8; it++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            for (int k = 0; k < 4 * DEPTH && pend_q.size() < n; k++) begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_x = WIDTH'($urandom);
                ld_w = WIDTH'($urandom);
                cycle();
            end
            ld_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) cycle();
            pulse_start();
            run_to_idle();
        end

        // Reset in the 2nd RUN cycle of a 4-pair run
        for (int j = 0; j < 4; j++) load(j + 1, j + 2);
        pulse_start();
        for (int k = 0; k < 8 && mdl_t != 3; k++) cycle();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        mdl_t = -1;
        pend_q.delete();
        run_q.delete();
        cycle();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
